// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit pipelined core.
//   state_e : memory-stage controller states
//   DATA_W  : datapath width
//   REG_W   : register-file index width
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller. Takes the Execute/Memory register outputs, runs
// loads/stores against a variable-latency req/ack data memory, freezes the
// upstream pipeline while a request is outstanding, and presents a registered
// writeback bundle to the Memory/Writeback boundary.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid                 EX/MEM register holds a real instruction
//   alu_result, rd1          address / ALU value, store data
//   dst_reg, reg_write       destination and register-file write intent
//   mem_read, mem_write      load / store (store wins when both set)
//   mem_en, mem_wr           memory request strobe and direction
//   mem_addr, mem_wdata      memory request address and store data
//   mem_ack, mem_rdata       memory completion and load data
//   stall                    hold EX/MEM and all earlier stages
//   wb_valid, wb_we          writeback bundle valid, register-file write
//   wb_dst, wb_data          writeback destination and data
//   mem_err                  sticky timeout flag
module mem_stage_ctrl
  import wisc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rd1,
  input  logic [REG_W-1:0]  dst_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state, state_nxt;
  logic [7:0]        cnt;
  logic              is_mem_op;
  logic              timeout_hit;

  // request latches, captured on accept and held for the whole access
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [REG_W-1:0]  lat_dst;
  logic              lat_we;
  logic              lat_wr;

  assign is_mem_op = in_valid & (mem_read | mem_write);

  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    stall       = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        stall = is_mem_op;
        if (is_mem_op) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en      = 1'b1;
        mem_wr      = lat_wr;
        mem_addr    = lat_addr;
        mem_wdata   = lat_wdata;
        // ack takes precedence over an expiring counter
        timeout_hit = ~mem_ack & (cnt == CNT_LAST);
        // release upstream on ack or abort; the held op is consumed either way
        stall       = ~mem_ack & ~timeout_hit;
        if (mem_ack | timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_err   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_dst    <= '0;
      wb_data   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_dst   <= '0;
      lat_we    <= 1'b0;
      lat_wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (is_mem_op) begin
            lat_addr  <= alu_result;
            lat_wdata <= rd1;
            lat_dst   <= dst_reg;
            lat_wr    <= mem_write;
            lat_we    <= reg_write & ~mem_write;  // stores never write the RF
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
          end else if (in_valid) begin
            wb_valid <= 1'b1;
            wb_we    <= reg_write;
            wb_dst   <= dst_reg;
            wb_data  <= alu_result;
          end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            cnt      <= '0;
            wb_valid <= 1'b1;
            wb_dst   <= lat_dst;
            wb_we    <= lat_we;
            // a completed store reports its address as the writeback value
            wb_data  <= lat_wr ? lat_addr : mem_rdata;
          end else if (timeout_hit) begin
            cnt      <= '0;
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
          end else begin
            cnt      <= cnt + 8'd1;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        default: begin
          cnt      <= '0;
          wb_valid <= 1'b0;
          wb_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
